// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path.
// Opcodes, ALUOp codes, ALU B-select codes, FSM states, control word.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_R_WB      = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_ILLEGAL   = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_insn;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure state-to-control-word decode for the multi-cycle FSM.
// MC_ILLEGAL_TRAP_EN makes the ILLEGAL state raise illegal_insn.
module mc_ctrl_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  output ctrl_t      o_ctrl
);

  ctrl_t w_c;

  always_comb begin
    w_c = '0;
    unique case (state_t'(i_state))
      S_FETCH: begin
        w_c.mem_read  = 1'b1;
        w_c.ir_write  = 1'b1;
        w_c.pc_write  = 1'b1;
        w_c.alu_src_b = SRCB_FOUR;
        w_c.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        w_c.alu_src_b = SRCB_IMM;
        w_c.alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        w_c.alu_src_a = 1'b1;
        w_c.alu_src_b = SRCB_RS2;
        w_c.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        w_c.reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        w_c.alu_src_a = 1'b1;
        w_c.alu_src_b = SRCB_IMM;
        w_c.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        w_c.mem_read = 1'b1;
        w_c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        w_c.reg_write  = 1'b1;
        w_c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        w_c.mem_write = 1'b1;
        w_c.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        w_c.alu_src_a     = 1'b1;
        w_c.alu_src_b     = SRCB_RS2;
        w_c.alu_op        = ALUOP_SUB;
        w_c.pc_write_cond = 1'b1;
        w_c.pc_source     = 1'b1;
      end
      S_ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
        w_c.illegal_insn = 1'b1;
`else
        w_c.illegal_insn = 1'b0;
`endif
      end
      default: w_c = '0;
    endcase
  end

  assign o_ctrl = w_c;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core.
// MC_ILLEGAL_TRAP_EN: unknown opcodes lock up in ILLEGAL instead of NOP.
module multicycle_control
  import rv32i_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               illegal_insn,
  output logic [STATE_W-1:0] state
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    unique case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (opcode)
          OP_RTYPE:           w_next = S_EXEC_R;
          OP_LOAD, OP_STORE:  w_next = S_MEM_ADDR;
          OP_BRANCH:          w_next = S_BRANCH;
          default:            w_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:    w_next = S_R_WB;
      S_R_WB:      w_next = S_FETCH;
      S_MEM_ADDR:  w_next = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_BRANCH:    w_next = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      S_ILLEGAL:   w_next = S_ILLEGAL;
`else
      S_ILLEGAL:   w_next = S_FETCH;
`endif
      default:     w_next = S_IDLE;
    endcase
  end

  mc_ctrl_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Only FETCH sets ir_write/pc_write, so gating them always is safe.
  always_comb begin
    pc_write      = w_ctrl.pc_write & mem_ready;
    ir_write      = w_ctrl.ir_write & mem_ready;
    pc_write_cond = w_ctrl.pc_write_cond;
    pc_source     = w_ctrl.pc_source;
    i_or_d        = w_ctrl.i_or_d;
    mem_read      = w_ctrl.mem_read;
    mem_write     = w_ctrl.mem_write;
    mem_to_reg    = w_ctrl.mem_to_reg;
    reg_write     = w_ctrl.reg_write;
    alu_src_a     = w_ctrl.alu_src_a;
    alu_src_b     = w_ctrl.alu_src_b;
    alu_op        = w_ctrl.alu_op;
    illegal_insn  = w_ctrl.illegal_insn;
  end

  assign state = STATE_W'(r_state);

endmodule
